// File: rtl/call_stack.sv
// rtl/call_stack.sv - parametrised return-address stack with overflow/underflow flags; optional hwm via CALL_STACK_HWM_EN
module call_stack #(
    parameter int DATA_W = 19,
    parameter int DEPTH  = 256,
    parameter int SPW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              call,
    input  logic              ret,
    input  logic [DATA_W-1:0] push_data,
    input  logic              err_clr,
    output logic [SPW-1:0]    sp,
    output logic [SPW-1:0]    count,
    output logic [DATA_W-1:0] stack_data,
    output logic              empty,
    output logic              full,
    output logic              err_ovf,
    output logic              err_unf,
    output logic [SPW-1:0]    hwm
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SPW-1:0] SP_EMPTY = SPW'(DEPTH);
    localparam logic [SPW-1:0] SP_TOP   = SPW'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [SPW-1:0] sp_q, sp_d;
    logic           err_ovf_q, err_ovf_d;
    logic           err_unf_q, err_unf_d;

    logic           mem_we;
    logic [SPW-1:0] mem_waddr;
    logic           ovf_set;
    logic           unf_set;

    assign empty = (sp_q == SP_EMPTY);
    assign full  = (sp_q == '0);
    assign sp    = sp_q;
    assign count = SP_EMPTY - sp_q;

    // Top of stack is hidden when empty so stale memory never leaks out.
    assign stack_data = empty ? '0 : mem[sp_q[AW-1:0]];

    assign err_ovf = err_ovf_q;
    assign err_unf = err_unf_q;

    // Decode call/ret into a memory write, a pointer move and error strobes.
    always_comb begin
        sp_d      = sp_q;
        mem_we    = 1'b0;
        mem_waddr = sp_q;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        if (call && !ret) begin
            if (full) begin
                ovf_set = 1'b1;
            end else begin
                mem_we    = 1'b1;
                mem_waddr = sp_q - 1'b1;
                sp_d      = sp_q - 1'b1;
            end
        end else if (ret && !call) begin
            if (empty) begin
                unf_set = 1'b1;
            end else begin
                sp_d = sp_q + 1'b1;
            end
        end else if (call && ret) begin
            mem_we = 1'b1;
            if (empty) begin
                // Nothing to replace: fall back to a plain push but still flag the bad ret.
                mem_waddr = SP_TOP;
                sp_d      = SP_TOP;
                unf_set   = 1'b1;
            end else begin
                // Tail call: overwrite the current top in place.
                mem_waddr = sp_q;
            end
        end
    end

    // Sticky flags; err_clr wins over an error raised in the same cycle.
    always_comb begin
        err_ovf_d = err_clr ? 1'b0 : (err_ovf_q | ovf_set);
        err_unf_d = err_clr ? 1'b0 : (err_unf_q | unf_set);
    end

    // Pointer and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q      <= SP_EMPTY;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            sp_q      <= sp_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    // Stack storage; not reset, and a reset cycle drops any pending write.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr[AW-1:0]] <= push_data;
        end
    end

`ifdef CALL_STACK_HWM_EN
    logic [SPW-1:0] hwm_q, hwm_d;
    logic [SPW-1:0] count_next;

    // High-water mark tracks the occupancy that the next state will have.
    always_comb begin
        count_next = SP_EMPTY - sp_d;
        if (err_clr) begin
            hwm_d = count_next;
        end else if (count_next > hwm_q) begin
            hwm_d = count_next;
        end else begin
            hwm_d = hwm_q;
        end
    end

    // High-water mark register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`else
    assign hwm = '0;
`endif

endmodule

// File: tb/tb_call_stack.sv
// tb/tb_call_stack.sv - table-driven self-checking bench for call_stack
module tb_call_stack;

    localparam int DATA_W = 19;
    localparam int DEPTH  = 256;
    localparam int SPW    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              call;
    logic              ret;
    logic [DATA_W-1:0] push_data;
    logic              err_clr;
    logic [SPW-1:0]    sp;
    logic [SPW-1:0]    count;
    logic [DATA_W-1:0] stack_data;
    logic              empty;
    logic              full;
    logic              err_ovf;
    logic              err_unf;
    logic [SPW-1:0]    hwm;

    int errors = 0;
    int checks = 0;

    call_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .call       (call),
        .ret        (ret),
        .push_data  (push_data),
        .err_clr    (err_clr),
        .sp         (sp),
        .count      (count),
        .stack_data (stack_data),
        .empty      (empty),
        .full       (full),
        .err_ovf    (err_ovf),
        .err_unf    (err_unf),
        .hwm        (hwm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        call;
        logic        ret;
        logic        err_clr;
        logic [18:0] data;
        int          e_sp;
        int          e_top;
        logic        e_ovf;
        logic        e_unf;
        int          e_hwm;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic c, logic t, logic ec, logic [18:0] d,
                                int s, int top, logic ovf, logic unf, int hw);
        vec_t v;
        v.rst = r; v.call = c; v.ret = t; v.err_clr = ec; v.data = d;
        v.e_sp = s; v.e_top = top; v.e_ovf = ovf; v.e_unf = unf; v.e_hwm = hw;
        return v;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    function automatic int exp_hwm(input int h);
`ifdef CALL_STACK_HWM_EN
        return h;
`else
        return 0 * h;
`endif
    endfunction

    task automatic cyc(input logic r, input logic c, input logic t, input logic ec,
                       input logic [18:0] d);
        rst = r; call = c; ret = t; err_clr = ec; push_data = d;
        @(posedge clk);
        #1;
        rst = 1'b0; call = 1'b0; ret = 1'b0; err_clr = 1'b0; push_data = '0;
    endtask

    task automatic check_state(input string tag, input int s, input int top,
                               input logic ovf, input logic unf, input int hw);
        check({tag, ".sp"}, int'(sp), s);
        check({tag, ".count"}, int'(count), DEPTH - s);
        check({tag, ".top"}, int'(stack_data), top);
        check({tag, ".empty"}, int'(empty), int'(s == DEPTH));
        check({tag, ".full"}, int'(full), int'(s == 0));
        check({tag, ".ovf"}, int'(err_ovf), int'(ovf));
        check({tag, ".unf"}, int'(err_unf), int'(unf));
        check({tag, ".hwm"}, int'(hwm), exp_hwm(hw));
    endtask

    initial begin
        //                 rst  call ret  clr  data       sp   top      ovf  unf  hwm
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,19'h00000, 256, 0,       1'b0,1'b0,0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,19'h00100, 255, 'h100,   1'b0,1'b0,1));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,19'h00200, 254, 'h200,   1'b0,1'b0,2));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,19'h00300, 253, 'h300,   1'b0,1'b0,3));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,19'h00000, 254, 'h200,   1'b0,1'b0,3));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,19'h00000, 255, 'h100,   1'b0,1'b0,3));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,19'h00000, 256, 0,       1'b0,1'b0,3));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,19'h00000, 256, 0,       1'b0,1'b1,3));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,19'h00ABC, 255, 'hABC,   1'b0,1'b1,3));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,19'h00000, 255, 'hABC,   1'b0,1'b0,1));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,19'h00002, 254, 'h2,     1'b0,1'b0,2));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,19'h00055, 254, 'h55,    1'b0,1'b0,2));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,19'h00000, 255, 'hABC,   1'b0,1'b0,2));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,19'h00000, 256, 0,       1'b0,1'b0,2));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,19'h00000, 256, 0,       1'b0,1'b0,0));
        vecs.push_back(mk(1'b1,1'b1,1'b0,1'b0,19'h00111, 256, 0,       1'b0,1'b0,0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,19'h00010, 255, 'h10,    1'b0,1'b0,1));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,19'h00011, 254, 'h11,    1'b0,1'b0,2));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,19'h00012, 253, 'h12,    1'b0,1'b0,3));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,19'h00013, 252, 'h13,    1'b0,1'b0,4));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,19'h00014, 251, 'h14,    1'b0,1'b0,5));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,19'h00000, 252, 'h13,    1'b0,1'b0,5));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,19'h00000, 253, 'h12,    1'b0,1'b0,5));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,19'h00000, 254, 'h11,    1'b0,1'b0,5));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,19'h00000, 254, 'h11,    1'b0,1'b0,2));

        rst = 1'b1; call = 1'b0; ret = 1'b0; err_clr = 1'b0; push_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_state("reset", 256, 0, 1'b0, 1'b0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst, vecs[i].call, vecs[i].ret, vecs[i].err_clr, vecs[i].data);
            check_state($sformatf("vec%0d", i), vecs[i].e_sp, vecs[i].e_top,
                        vecs[i].e_ovf, vecs[i].e_unf, vecs[i].e_hwm);
        end

        // Fill the whole stack, then probe the full-boundary behaviour.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 19'(i + 1));
        end
        check_state("filled", 0, DEPTH, 1'b0, 1'b0, DEPTH);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 19'h7FFFF);
        check_state("ovf", 0, DEPTH, 1'b1, 1'b0, DEPTH);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
        check_state("ovf_clr", 0, DEPTH, 1'b0, 1'b0, DEPTH);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 19'h7FFFF);
        check_state("ovf_vs_clr", 0, DEPTH, 1'b0, 1'b0, DEPTH);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 19'h00055);
        check_state("full_replace", 0, 'h55, 1'b0, 1'b0, DEPTH);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
        check_state("pop_from_full", 1, DEPTH - 1, 1'b0, 1'b0, DEPTH);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 19'h7FFFF);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 19'h12345);
        check_state("refull_ovf", 0, 'h7FFFF, 1'b1, 1'b0, DEPTH);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, '0);
        check_state("rst_midop", 256, 0, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
